// File: rtl/bcd_time_pkg.sv
// Shared types and BCD arithmetic for the BCD time keeper.
package bcd_time_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADJ_FWD,
    S_ADJ_BACK,
    S_DONE
  } adj_state_e;

  typedef struct packed {
    logic [3:0] hours_tens;
    logic [3:0] hours_ones;
    logic [3:0] minutes_tens;
    logic [3:0] minutes_ones;
    logic [3:0] seconds_tens;
    logic [3:0] seconds_ones;
  } bcd_time_t;

  // One minute forward with hour carry, 23:59 -> 00:00. Seconds untouched.
  function automatic bcd_time_t bcd_inc_minute(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.minutes_ones == 4'd9) begin
      r.minutes_ones = '0;
      if (t.minutes_tens == 4'd5) begin
        r.minutes_tens = '0;
        if (t.hours_tens == 4'd2 && t.hours_ones == 4'd3) begin
          r.hours_tens = '0;
          r.hours_ones = '0;
        end else if (t.hours_ones == 4'd9) begin
          r.hours_ones = '0;
          r.hours_tens = t.hours_tens + 4'd1;
        end else begin
          r.hours_ones = t.hours_ones + 4'd1;
        end
      end else begin
        r.minutes_tens = t.minutes_tens + 4'd1;
      end
    end else begin
      r.minutes_ones = t.minutes_ones + 4'd1;
    end
    return r;
  endfunction

  // One second forward with full ripple carry.
  function automatic bcd_time_t bcd_inc_time(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.seconds_ones == 4'd9) begin
      r.seconds_ones = '0;
      if (t.seconds_tens == 4'd5) begin
        r.seconds_tens = '0;
        r = bcd_inc_minute(r);
      end else begin
        r.seconds_tens = t.seconds_tens + 4'd1;
      end
    end else begin
      r.seconds_ones = t.seconds_ones + 4'd1;
    end
    return r;
  endfunction

  // One minute backward with hour borrow, 00:00 -> 23:59. Seconds untouched.
  function automatic bcd_time_t bcd_dec_minute(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.minutes_ones == 4'd0) begin
      r.minutes_ones = 4'd9;
      if (t.minutes_tens == 4'd0) begin
        r.minutes_tens = 4'd5;
        if (t.hours_tens == 4'd0 && t.hours_ones == 4'd0) begin
          r.hours_tens = 4'd2;
          r.hours_ones = 4'd3;
        end else if (t.hours_ones == 4'd0) begin
          r.hours_ones = 4'd9;
          r.hours_tens = t.hours_tens - 4'd1;
        end else begin
          r.hours_ones = t.hours_ones - 4'd1;
        end
      end else begin
        r.minutes_tens = t.minutes_tens - 4'd1;
      end
    end else begin
      r.minutes_ones = t.minutes_ones - 4'd1;
    end
    return r;
  endfunction

  // 24 h hour digits to 12 h display digits {tens, ones}.
  function automatic logic [7:0] to_12h(input logic [3:0] ht, input logic [3:0] ho);
    logic [7:0] r;
    r = {ht, ho};
    if (ht == 4'd0 && ho == 4'd0) begin
      r = 8'h12;
    end else if (ht == 4'd1 && ho >= 4'd3) begin
      r = {4'd0, ho - 4'd2};
    end else if (ht == 4'd2) begin
      if (ho < 4'd2) r = {4'd0, ho + 4'd8};
      else           r = {4'd1, ho - 4'd2};
    end
    return r;
  endfunction

  function automatic logic is_pm(input logic [3:0] ht, input logic [3:0] ho);
    return (ht == 4'd2) || (ht == 4'd1 && ho >= 4'd2);
  endfunction

  // True for a legal 24 h {HH, MM} BCD value.
  function automatic logic hm_valid(input logic [15:0] hm);
    logic ok;
    ok = (hm[15:12] <= 4'd2) && (hm[11:8] <= 4'd9) &&
         (hm[7:4] <= 4'd5) && (hm[3:0] <= 4'd9);
    if (hm[15:12] == 4'd2 && hm[11:8] > 4'd3) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_time_keeper_btn_debounce.sv
// Button debouncer: output rises after DEBOUNCE_CYCLES consecutive high
// samples, drops on any low sample; press_pulse marks the rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;

  // Count stable-high samples; any low sample restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!btn_in) begin
      cnt_d    = '0;
      stable_d = 1'b0;
    end else if (!stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = 1'b1;
      else                   cnt_d    = cnt_q + 1'b1;
    end
    press_d = stable_d & ~stable_q;
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/bcd_time_keeper.sv
// 24 h BCD time keeper with fwd/back minute-step adjust, 12/24 h display
// and alarm strobe.
module bcd_time_keeper
  import bcd_time_pkg::*;
#(
  parameter int CLOCK_FREQ       = 50_000_000,
  parameter int DEBOUNCE_TIME_MS = 20,
  parameter int STEP_MINUTES     = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fwd_btn,
  input  logic        back_btn,
  input  logic        mode_12h,
  input  logic        alarm_en,
  input  logic [15:0] alarm_bcd,
  output logic [3:0]  BCD_seconds_ones,
  output logic [3:0]  BCD_seconds_tens,
  output logic [3:0]  BCD_minutes_ones,
  output logic [3:0]  BCD_minutes_tens,
  output logic [3:0]  BCD_hours_ones,
  output logic [3:0]  BCD_hours_tens,
  output logic        pm,
  output logic        busy,
  output logic        second_tick,
  output logic        alarm_pulse
);

  // Multiply before dividing in 64 bits so sub-kHz clocks keep their value.
  localparam int DEBOUNCE_CYCLES = int'(longint'(CLOCK_FREQ) * DEBOUNCE_TIME_MS / 1000);
  localparam int CNT_W = $clog2(CLOCK_FREQ);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLOCK_FREQ - 1);
  localparam logic [5:0]       STEP_LAST = 6'(STEP_MINUTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  adj_state_e       state_q, state_d;
  bcd_time_t        time_q, time_d;
  logic [5:0]       step_q, step_d;
  logic             pending_q, pending_d;
  logic             alarm_q, alarm_d;
  logic             advance;
  logic             fwd_press, back_press;
  logic [7:0]       hours_12;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fwd_db (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (fwd_btn),
    .press_pulse (fwd_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (back_btn),
    .press_pulse (back_press)
  );

  // Free-running seconds divider, independent of the adjust FSM.
  always_comb begin
    second_tick = (cnt_q == TICK_LAST);
    cnt_d       = second_tick ? '0 : cnt_q + 1'b1;
  end

  // Adjust FSM, time update and alarm detection.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    step_d    = step_q;
    pending_d = pending_q;
    alarm_d   = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE: begin
        step_d  = '0;
        advance = second_tick;
        if (fwd_press && !back_press)      state_d = S_ADJ_FWD;
        else if (back_press && !fwd_press) state_d = S_ADJ_BACK;
      end
      S_ADJ_FWD, S_ADJ_BACK: begin
        time_d = (state_q == S_ADJ_FWD) ? bcd_inc_minute(time_q) : bcd_dec_minute(time_q);
        if (second_tick) pending_d = 1'b1;
        if (step_q == STEP_LAST) state_d = S_DONE;
        else                     step_d  = step_q + 6'd1;
      end
      S_DONE: begin
        // A tick arriving in this very cycle is folded into the pending one.
        advance   = pending_q | second_tick;
        pending_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      time_d  = bcd_inc_time(time_q);
      alarm_d = alarm_en && hm_valid(alarm_bcd) &&
                time_d.seconds_tens == 4'd0 && time_d.seconds_ones == 4'd0 &&
                {time_d.hours_tens, time_d.hours_ones,
                 time_d.minutes_tens, time_d.minutes_ones} == alarm_bcd;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      time_q    <= '0;
      step_q    <= '0;
      pending_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      time_q    <= time_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      alarm_q   <= alarm_d;
    end
  end

  // Display conversion and status outputs.
  always_comb begin
    hours_12         = to_12h(time_q.hours_tens, time_q.hours_ones);
    BCD_seconds_ones = time_q.seconds_ones;
    BCD_seconds_tens = time_q.seconds_tens;
    BCD_minutes_ones = time_q.minutes_ones;
    BCD_minutes_tens = time_q.minutes_tens;
    if (mode_12h) begin
      BCD_hours_tens = hours_12[7:4];
      BCD_hours_ones = hours_12[3:0];
    end else begin
      BCD_hours_tens = time_q.hours_tens;
      BCD_hours_ones = time_q.hours_ones;
    end
    pm          = is_pm(time_q.hours_tens, time_q.hours_ones);
    busy        = (state_q != S_IDLE);
    alarm_pulse = alarm_q;
  end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Self-checking bench for bcd_time_keeper (CLOCK_FREQ=100, 10-cycle debounce,
// 15-minute step).
module tb_bcd_time_keeper;

  logic        clk = 1'b0;
  logic        reset_n, fwd_btn, back_btn, mode_12h, alarm_en;
  logic [15:0] alarm_bcd;
  logic [3:0]  s_o, s_t, m_o, m_t, h_o, h_t;
  logic        pm, busy, second_tick, alarm_pulse;

  bcd_time_keeper #(
    .CLOCK_FREQ       (100),
    .DEBOUNCE_TIME_MS (100),
    .STEP_MINUTES     (15)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fwd_btn          (fwd_btn),
    .back_btn         (back_btn),
    .mode_12h         (mode_12h),
    .alarm_en         (alarm_en),
    .alarm_bcd        (alarm_bcd),
    .BCD_seconds_ones (s_o),
    .BCD_seconds_tens (s_t),
    .BCD_minutes_ones (m_o),
    .BCD_minutes_tens (m_t),
    .BCD_hours_ones   (h_o),
    .BCD_hours_tens   (h_t),
    .pm               (pm),
    .busy             (busy),
    .second_tick      (second_tick),
    .alarm_pulse      (alarm_pulse)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset released (the bench's own time base).
  int k;
  always @(posedge clk) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int adj      = 0;   // net adjust minutes since reset

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] disp();
    return {h_t, h_o, m_t, m_o, s_t, s_o};
  endfunction

  function automatic logic [23:0] model_time(input int edges, input int adj_min);
    int sod, h, m, s;
    sod = (((edges / 100) + 60 * adj_min) % 86400 + 86400) % 86400;
    h = sod / 3600;
    m = (sod / 60) % 60;
    s = sod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Output monitor, sampled shortly after the falling edge.
  int          tick_total = 0, tick_wide = 0, tick_misplaced = 0, alarm_total = 0;
  logic        prev_tick = 1'b0;
  logic [23:0] alarm_disp = '0;
  always @(negedge clk) begin
    #2;
    if (second_tick) begin
      tick_total++;
      if (prev_tick) tick_wide++;
      if (k % 100 != 99) tick_misplaced++;
    end
    prev_tick = second_tick;
    if (alarm_pulse) begin
      alarm_total++;
      alarm_disp = disp();
    end
  end

  typedef struct {
    string       tag;
    logic [23:0] exp_time;
    int          exp_rise;
    int          exp_len;
  } adj_exp_t;
  adj_exp_t sb_q[$];

  // Clean press held 12 cycles; expectation queued at press, compared when busy drops.
  task automatic run_adjust(input string tag, input logic fwd, input int delta);
    adj_exp_t    e;
    int          rise, len, fall;
    logic [23:0] got_time;
    rise = 0; len = 0; fall = 0; got_time = '1;
    e.tag      = tag;
    e.exp_time = model_time(k + 27, adj + delta);
    e.exp_rise = 11;
    e.exp_len  = 16;
    sb_q.push_back(e);
    if (fwd) fwd_btn = 1'b1;
    else     back_btn = 1'b1;
    for (int i = 1; i <= 60 && fall == 0; i++) begin
      @(negedge clk);
      if (i == 12) begin
        fwd_btn  = 1'b0;
        back_btn = 1'b0;
      end
      if (busy) begin
        len++;
        if (rise == 0) rise = i;
      end else if (rise != 0) begin
        fall     = i;
        got_time = disp();
      end
    end
    fwd_btn  = 1'b0;
    back_btn = 1'b0;
    adj += delta;
    e = sb_q.pop_front();
    check_eq({e.tag, "_rise"}, rise, e.exp_rise);
    check_eq({e.tag, "_busy_len"}, len, e.exp_len);
    check_eq({e.tag, "_time"}, got_time, e.exp_time);
  endtask

  task automatic wait_until_k(input int target);
    while (k < target) @(negedge clk);
  endtask

  initial begin
    int t0, a0, busy_seen;
    logic [23:0] exp;
    reset_n = 1'b0; fwd_btn = 1'b0; back_btn = 1'b0;
    mode_12h = 1'b0; alarm_en = 1'b0; alarm_bcd = 16'h0001;
    repeat (3) @(negedge clk);
    check_eq("rst_time", disp(), 24'h000000);
    check_eq("rst_flags", {busy, pm, second_tick, alarm_pulse}, 4'b0000);
    mode_12h = 1'b1;
    @(negedge clk);
    check_eq("rst_12h", {disp(), pm}, {24'h120000, 1'b0});
    mode_12h = 1'b0;

    // One minute of free running; alarm matches 00:01 but is disabled.
    t0 = tick_total; a0 = alarm_total;
    reset_n = 1'b1;
    wait_until_k(6000);
    check_eq("time_1min", disp(), 24'h000100);
    check_eq("ticks_1min", tick_total - t0, 60);
    check_eq("tick_width", tick_wide, 0);
    check_eq("tick_phase", tick_misplaced, 0);
    check_eq("alarm_en0", alarm_total - a0, 0);

    run_adjust("back_wrap", 1'b0, -15);
    check_eq("back_wrap_abs", {disp(), pm}, {24'h234600, 1'b1});
    repeat (3) @(negedge clk);
    run_adjust("fwd_wrap", 1'b1, 15);
    check_eq("fwd_wrap_abs", {disp(), pm}, {24'h000100, 1'b0});

    // Simultaneous presses cancel.
    fwd_btn = 1'b1; back_btn = 1'b1; busy_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 12) begin fwd_btn = 1'b0; back_btn = 1'b0; end
      if (busy) busy_seen++;
    end
    check_eq("both_ignored", busy_seen, 0);
    check_eq("both_time", disp(), model_time(k, adj));

    // Second run: bounce, hour stepping, alarm, 12 h view, pending tick.
    reset_n = 1'b0; adj = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fwd_btn = 1'b1; busy_seen = 0;
    repeat (5) begin @(negedge clk); if (busy) busy_seen++; end
    fwd_btn = 1'b0;
    @(negedge clk);
    if (busy) busy_seen++;
    check_eq("bounce_quiet", busy_seen, 0);
    run_adjust("bounce", 1'b1, 15);

    for (int i = 0; i < 27; i++) begin
      run_adjust("fwd_to_7h", 1'b1, 15);
      repeat (2) @(negedge clk);
    end
    check_eq("at_7h", disp(), model_time(k, adj));

    alarm_bcd = 16'h0701; alarm_en = 1'b1; a0 = alarm_total;
    wait_until_k(6005);
    check_eq("alarm_count", alarm_total - a0, 1);
    check_eq("alarm_time", alarm_disp, 24'h070100);

    a0 = alarm_total;
    run_adjust("back_646", 1'b0, -15);
    repeat (2) @(negedge clk);
    run_adjust("fwd_701", 1'b1, 15);
    repeat (4) @(negedge clk);
    check_eq("alarm_adjust_quiet", alarm_total - a0, 0);

    for (int i = 0; i < 24; i++) begin
      run_adjust("fwd_to_13h", 1'b1, 15);
      repeat (2) @(negedge clk);
    end
    mode_12h = 1'b1;
    @(negedge clk);
    exp = model_time(k, adj);
    exp[23:16] = 8'h01;
    check_eq("h12_13h", disp(), exp);
    check_eq("h12_pm", pm, 1'b1);
    mode_12h = 1'b0;

    wait_until_k(11980);
    check_eq("pre_pending", disp(), 24'h130159);
    run_adjust("tick_mid_adj", 1'b1, 15);
    check_eq("pending_applied", disp(), 24'h131700);

    // Reset in the middle of an adjust.
    fwd_btn = 1'b1; busy_seen = 0;
    for (int i = 0; i < 30 && busy_seen == 0; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check_eq("abort_started", busy_seen, 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0; fwd_btn = 1'b0; adj = 0;
    repeat (2) @(negedge clk);
    check_eq("abort_time", disp(), 24'h000000);
    check_eq("abort_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("after_abort", {disp(), busy}, {model_time(k, 0), 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
